counter_share_arbiter: RTL

- Shares one up-counter of the same kind as our simulation counter among NUM_REQ requesters.
- Each requester asks for a timed interval of req_len clock cycles.
- Requesters are granted round-robin; the shared counter runs for the interval, then a one-cycle done pulse goes back to the owner.
- Sits between the test/sequencing logic and the counter datapath; the counter itself is instantiated as a sub-module.

---
 rtl/counter_share_arbiter_pkg.sv | 22 ++
 rtl/counter_share_arbiter_counter.sv | 13 +
 rtl/counter_share_arbiter.sv | 71 +++++++
 3 files changed

// File: rtl/counter_share_arbiter_pkg.sv
// counter_share_arbiter_pkg: arbiter state type and round-robin pick helper
package counter_share_arbiter_pkg;
   localparam int MAX_REQ = 16;
   localparam int IDX_W = $clog2(MAX_REQ);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   // First set bit of valid searching upward from last+1, wrapping at n.
   function automatic logic [IDX_W-1:0] rr_next(input logic [MAX_REQ-1:0] valid, input logic [IDX_W-1:0] last, input int n);
      logic [IDX_W-1:0] pick;
      logic hit;
      int j;
      pick = '0;
      hit = 1'b0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         j = (int'(last) + k) % n;
         if (k <= n && !hit && valid[j[IDX_W-1:0]]) begin
            pick = j[IDX_W-1:0];
            hit = 1'b1;
         end
      end
      return pick;
   endfunction
endpackage

// File: rtl/counter_share_arbiter_counter.sv
// shared_counter: up-counter with synchronous clear and count enable
module shared_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] value
);
   always_ff @(posedge clk)
      value <= (reset || clear) ? '0 : enable ? value + 1'b1 : value;
endmodule

// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: round-robin sharing of one interval counter among requesters
module counter_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_len,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       abort,
   output logic [NUM_REQ-1:0]         done,
   output logic                       done_aborted,
   output logic                       busy,
   output logic [WIDTH-1:0]           cnt_value,
   output logic [$clog2(NUM_REQ)-1:0] owner
);
   import counter_share_arbiter_pkg::*;
   localparam int OW = $clog2(NUM_REQ);
   state_t state, state_n;
   logic [WIDTH-1:0] len, sel_len, cnt;
   logic [OW-1:0] last_grant;
   logic [IDX_W-1:0] pick;
   logic aborted, accept, terminal, abort_hit, clear, enable;
   always_comb begin
      pick = rr_next(MAX_REQ'(req_valid), IDX_W'(last_grant), NUM_REQ);
      sel_len = '0;
      for (int i = 0; i < NUM_REQ; i++)
         sel_len = (pick == IDX_W'(i)) ? req_len[i*WIDTH +: WIDTH] : sel_len;
   end
   assign accept    = state == IDLE && |req_valid;
   assign terminal  = cnt == len;
   assign abort_hit = state == RUN && abort && !terminal;
   always_comb begin
      state_n = state == IDLE ? (accept ? RUN : IDLE) :
                state == RUN  ? ((terminal || abort) ? DONE : RUN) : IDLE;
   end
   // Counting on the accepting edge makes the first RUN cycle show 1.
   assign clear     = state == DONE || (state == IDLE && !accept);
   assign enable    = accept || (state == RUN && !terminal && !abort);
   assign req_ready = accept ? NUM_REQ'(1) << pick : '0;
   assign done      = state == DONE ? NUM_REQ'(1) << owner : '0;
   assign done_aborted = state == DONE && aborted;
   assign busy      = state != IDLE;
   assign cnt_value = cnt;
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         len        <= '0;
         owner      <= '0;
         last_grant <= OW'(NUM_REQ - 1);
         aborted    <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            len     <= sel_len == '0 ? WIDTH'(1) : sel_len;
            owner   <= OW'(pick);
            aborted <= 1'b0;
         end
         if (abort_hit) aborted <= 1'b1;
         if (state == DONE) last_grant <= owner;
      end
   end
   shared_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .enable (enable),
      .value  (cnt)
   );
endmodule
